// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Single-cycle data-memory responder for a small CPU. It holds
//               a word-addressed RAM and a 16-byte I/O window containing LED,
//               switch, free-running cycle counter and sticky status
//               registers. Reads are combinational; writes land at posedge.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int          RAM_WORDS = 64,
    parameter logic [15:0] IO_BASE   = 16'hFFF0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] dmemaddr,
    input  logic [15:0] dmemwdata,
    input  logic        dmemwrite,
    input  logic        dmemread,
    input  logic [7:0]  switches,
    output logic [15:0] dmemrdata,
    output logic [7:0]  leds,
    output logic        err
);

    // Word-index width; a 1-word RAM still needs a 1-bit index slice.
    localparam int          c_aw        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [16:0] c_ram_bytes = 17'(2 * RAM_WORDS);

    // Register offsets (word number inside the I/O window)
    localparam logic [2:0] c_off_led  = 3'd0;
    localparam logic [2:0] c_off_sw   = 3'd1;
    localparam logic [2:0] c_off_cyc  = 3'd2;
    localparam logic [2:0] c_off_stat = 3'd3;

    logic [15:0]     r_ram [RAM_WORDS];
    logic [7:0]      r_led;
    logic [15:0]     r_cycle;
    logic            r_fault;
    logic            r_ovf;
    logic [7:0]      r_sw_meta;
    logic [7:0]      r_sw_sync;

    logic            w_io_win;
    logic            w_sel_ram;
    logic            w_sel_led;
    logic            w_sel_sw;
    logic            w_sel_cyc;
    logic            w_sel_stat;
    logic            w_unmapped;
    logic [c_aw-1:0] w_word_idx;
    logic            w_fault_set;
    logic            w_ovf_set;
    logic [1:0]      w_stat_clr;
    logic [15:0]     w_cycle_next;
    logic [15:0]     w_rdata;
    logic            w_unused;

    // Byte address bit 0 carries no meaning for 16-bit accesses.
    assign w_unused = dmemaddr[0];

    // Address decode. The I/O window takes priority over RAM so that a RAM
    // large enough to overlap the window never shadows the registers.
    assign w_io_win   = (dmemaddr[15:4] == IO_BASE[15:4]);
    assign w_sel_led  = w_io_win && (dmemaddr[3:1] == c_off_led);
    assign w_sel_sw   = w_io_win && (dmemaddr[3:1] == c_off_sw);
    assign w_sel_cyc  = w_io_win && (dmemaddr[3:1] == c_off_cyc);
    assign w_sel_stat = w_io_win && (dmemaddr[3:1] == c_off_stat);
    assign w_sel_ram  = !w_io_win && ({1'b0, dmemaddr} < c_ram_bytes);
    assign w_unmapped = !(w_sel_ram || w_sel_led || w_sel_sw || w_sel_cyc || w_sel_stat);
    assign w_word_idx = dmemaddr[c_aw:1];

    // Fault sources: simultaneous read+write, any unmapped access, or a write
    // to the read-only switch register.
    assign w_fault_set = (dmemread && dmemwrite)
                      || ((dmemread || dmemwrite) && w_unmapped)
                      || (dmemwrite && w_sel_sw);
    assign w_ovf_set   = (r_cycle == 16'hFFFF);
    assign w_stat_clr  = (dmemwrite && w_sel_stat) ? dmemwdata[1:0] : 2'b00;

    // A write to CYCLE clears it; this still counts as a wrap for overflow.
    assign w_cycle_next = (dmemwrite && w_sel_cyc) ? 16'h0000 : (r_cycle + 16'd1);

    // Combinational read mux; returns pre-write state during a write cycle.
    always_comb begin
        w_rdata = 16'h0000;
        if (dmemread) begin
            if (w_sel_ram)       w_rdata = r_ram[w_word_idx];
            else if (w_sel_led)  w_rdata = {8'h00, r_led};
            else if (w_sel_sw)   w_rdata = {8'h00, r_sw_sync};
            else if (w_sel_cyc)  w_rdata = r_cycle;
            else if (w_sel_stat) w_rdata = {14'h0000, r_ovf, r_fault};
        end
    end

    // RAM array: never reset, and writes are dropped while reset is high.
    always_ff @(posedge clock) begin
        if (!reset && dmemwrite && w_sel_ram)
            r_ram[w_word_idx] <= dmemwdata;
    end

    // Control/status registers and switch synchronizer.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_led     <= 8'h00;
            r_cycle   <= 16'h0000;
            r_fault   <= 1'b0;
            r_ovf     <= 1'b0;
            r_sw_meta <= 8'h00;
            r_sw_sync <= 8'h00;
        end else begin
            if (dmemwrite && w_sel_led)
                r_led <= dmemwdata[7:0];
            r_cycle   <= w_cycle_next;
            // New set events win over a coincident write-1-to-clear.
            r_fault   <= (r_fault && !w_stat_clr[0]) || w_fault_set;
            r_ovf     <= (r_ovf   && !w_stat_clr[1]) || w_ovf_set;
            r_sw_meta <= switches;
            r_sw_sync <= r_sw_meta;
        end
    end

    assign dmemrdata = w_rdata;
    assign leds      = r_led;
    assign err       = r_fault;

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter RAM_WORDS, default 64, number of 16-bit RAM words; SHALL be a power of two, maximum 32768.
REQ-002 Parameter IO_BASE, default 16'hFFF0, base byte address of the I/O register window; SHALL be 16-byte aligned.
REQ-003 clock  input  1  sole clock; all state updates on posedge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 dmemaddr  input  16  byte address from the CPU MEM stage; bit 0 ignored.
REQ-006 dmemwdata  input  16  write data.
REQ-007 dmemwrite  input  1  write enable.
REQ-008 dmemread  input  1  read enable.
REQ-009 switches  input  8  asynchronous board switch inputs.
REQ-010 dmemrdata  output  16  read data, valid in the same cycle as the request.
REQ-011 leds  output  8  LED register contents.
REQ-012 err  output  1  copy of STATUS bit 0 (sticky fault).

Function
REQ-013 The RAM region SHALL be bytes 0 to 2*RAM_WORDS-1, word index = dmemaddr[log2(RAM_WORDS):1].
REQ-014 I/O registers SHALL be: IO_BASE+0 LED (R/W, bits 7:0); +2 SW (RO); +4 CYCLE (RO count, any write clears it); +6 STATUS (bit0 fault, bit1 overflow, write-1-to-clear). Unused bits SHALL read 0.
REQ-015 Every other address SHALL be unmapped: reads return 16'h0000, writes have no effect.
REQ-016 Reads SHALL be combinational: dmemrdata reflects the addressed location in the same cycle with zero latency, with no clock edge required.
REQ-017 dmemrdata SHALL be 16'h0000 whenever dmemread=0.
REQ-018 A write SHALL update the addressed RAM word or register at the posedge where dmemwrite=1; a read in that cycle returns the pre-write value.
REQ-019 If dmemread=1 and dmemwrite=1 in the same cycle, the write SHALL be performed, the read SHALL return the pre-write value, and STATUS.fault SHALL be set.
REQ-020 Any read or write to an unmapped address, or any write to SW, SHALL set STATUS.fault at the next posedge.
REQ-021 SW SHALL read {8'h00, switches} through a two-flop synchronizer, a latency of 2 clocks.
REQ-022 CYCLE SHALL increment by 1 every clock. On the transition 16'hFFFF->16'h0000 it SHALL wrap and set STATUS.overflow.
REQ-023 If a CYCLE write coincides with a wrap, CYCLE SHALL become 0 and STATUS.overflow SHALL still be set.
REQ-024 If a STATUS write-1-clear coincides with a new set event for the same bit, the set SHALL win.
REQ-025 Writes to LED SHALL store only dmemwdata[7:0]; leds SHALL update at the write posedge.
REQ-026 The block SHALL contain no handshake stalls; every request completes in its own cycle.

Reset
REQ-027 With reset=1 at a posedge, leds, CYCLE, STATUS, and both synchronizer stages SHALL become 0, and err SHALL become 0.
REQ-028 Reset SHALL take priority over any simultaneous write. Writes in reset cycles SHALL be discarded, including RAM writes.
REQ-029 RAM contents SHALL NOT be altered by reset.
REQ-030 In the first cycle after reset deasserts, CYCLE SHALL read 0; it SHALL read 1 in the following cycle.

Verification
REQ-031 Write 16'hBEEF to 0x0010, then read 0x0010 next cycle -> dmemrdata=16'hBEEF in the read cycle; reading 0x0012 returns its prior value.
REQ-032 Write 16'h12A5 to 0xFFF0 -> leds=8'hA5 after that posedge; read 0xFFF0 returns 16'h00A5.
REQ-033 Read 0x0100 (unmapped) -> dmemrdata=0 and err=1 next cycle; write 16'h0001 to 0xFFF6 -> err=0.
REQ-034 Run 65536 clocks after reset -> CYCLE reads 0 and STATUS reads 16'h0002; write CYCLE during the wrap cycle -> CYCLE=0 and overflow=1.
REQ-035 Set switches=8'h3C -> SW reads 16'h0000 one cycle later and 16'h003C two cycles later.
REQ-036 Write 16'h5555 to 0x0004, assert reset for 3 cycles, then read 0x0004 -> 16'h5555, while leds, CYCLE, and STATUS read 0.
